// File: rtl/pwm.sv
// ---------------------------------------------------------------------------
// pwm : single-channel, fixed-period PWM generator.
//
// A prescaler divides clk into counter ticks; a period counter runs
// 0..PERIOD-1 on those ticks and the pin is high while the counter is below
// a double-buffered duty threshold. The threshold is only re-sampled at the
// period wrap, so a control register can update duty_cycle at any time
// without producing runt pulses.
//
// Parameters
//   WIDTH    : width of duty_cycle and the period counter (PERIOD <= 2**WIDTH)
//   PERIOD   : counter ticks per PWM period, 2..2**WIDTH
//   PRESCALE : clocks per counter tick, >= 1 (1 = tick every clock)
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   duty_cycle : requested high time in ticks per period
//   out        : registered PWM output
// ---------------------------------------------------------------------------
module pwm #(
  parameter int WIDTH    = 8,
  parameter int PERIOD   = 100,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] duty_cycle,
  output logic             out
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  if (WIDTH < 1 || WIDTH > 30) begin : g_bad_width
    $fatal(1, "pwm: WIDTH must be in 1..30");
  end
  if (PERIOD < 2) begin : g_bad_period_lo
    $fatal(1, "pwm: PERIOD must be >= 2");
  end
  if (WIDTH >= 1 && WIDTH <= 30 && PERIOD > (1 << WIDTH)) begin : g_bad_period_hi
    $fatal(1, "pwm: PERIOD must be <= 2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $fatal(1, "pwm: PRESCALE must be >= 1");
  end

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(PERIOD - 1);

  // -------------------------------------------------------------------------
  // Prescaler: tick is high on the last clock of each tick interval
  // -------------------------------------------------------------------------
  logic tick;

  if (PRESCALE > 1) begin : g_psc
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
    logic [PS_W-1:0] psc;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             psc <= '0;
      else if (psc == PS_MAX) psc <= '0;
      else                    psc <= psc + 1'b1;
    end

    assign tick = (psc == PS_MAX);
  end else begin : g_no_psc
    assign tick = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Period counter, duty shadow and output
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_sh;
  logic             loaded;   // low until the first edge after reset
  logic             wrap;
  logic [WIDTH-1:0] duty_eff;

  assign wrap = tick && (cnt == CNT_MAX);

  // On the very first edge after reset the shadow still holds 0, so the
  // compare uses duty_cycle directly; this keeps the first period's high
  // time identical to every later one (cnt=0 is not lost). Still a purely
  // registered path to the pin.
  assign duty_eff = loaded ? duty_sh : duty_cycle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      duty_sh <= '0;
      loaded  <= 1'b0;
      out     <= 1'b0;
    end else begin
      loaded <= 1'b1;
      if (wrap || !loaded) duty_sh <= duty_cycle;
      if (wrap)            cnt     <= '0;
      else if (tick)       cnt     <= cnt + 1'b1;
      // cnt never exceeds PERIOD-1, so any duty >= PERIOD saturates high.
      out <= (cnt < duty_eff);
    end
  end

endmodule

// File: tb/tb_pwm.sv
// ---------------------------------------------------------------------------
// tb_pwm : scoreboard bench for pwm.
// dut_a : WIDTH=8, PERIOD=100, PRESCALE=1
// dut_b : WIDTH=8, PERIOD=10,  PRESCALE=4
// The stimulus process pushes the hand-derived pin value for each future
// clock (keyed by cycle number) into a per-DUT queue; the monitor samples
// each pin on the falling edge and pops/compares whenever an entry is due.
// ---------------------------------------------------------------------------
module tb_pwm;

  logic       clk = 1'b0;
  logic       rst_a_n, rst_b_n;
  logic [7:0] duty_a, duty_b;
  logic       out_a, out_b;

  always #5 clk = ~clk;

  pwm #(.WIDTH(8), .PERIOD(100), .PRESCALE(1)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .duty_cycle(duty_a), .out(out_a)
  );

  pwm #(.WIDTH(8), .PERIOD(10), .PRESCALE(4)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .duty_cycle(duty_b), .out(out_b)
  );

  typedef struct {
    int   cyc;
    logic val;
    int   seg;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;
  int ep_a, ep_b, seg;
  int r_a, r_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: out=%b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_a(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      qa.push_back('{ep_a, v, seg});
      ep_a++;
    end
  endtask

  task automatic push_b(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      qb.push_back('{ep_b, v, seg});
      ep_b++;
    end
  endtask

  task automatic period_a(input int hi, input int lo);
    push_a(1'b1, hi);
    push_a(1'b0, lo);
  endtask

  task automatic period_b(input int hi, input int lo);
    push_b(1'b1, hi);
    push_b(1'b0, lo);
  endtask

  // cyc always advances, so this always returns
  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (qa.size() > 0 && qa[0].cyc < cyc) begin
      ea = qa.pop_front();
      n_vec++; n_err++;
      $display("FAIL a_seg%0d_missed: cycle %0d not sampled, now %0d", ea.seg, ea.cyc, cyc);
    end
    if (qa.size() > 0 && qa[0].cyc == cyc) begin
      ea = qa.pop_front();
      check($sformatf("a_seg%0d", ea.seg), out_a, ea.val);
    end
    if (qb.size() > 0 && qb[0].cyc < cyc) begin
      eb = qb.pop_front();
      n_vec++; n_err++;
      $display("FAIL b_seg%0d_missed: cycle %0d not sampled, now %0d", eb.seg, eb.cyc, cyc);
    end
    if (qb.size() > 0 && qb[0].cyc == cyc) begin
      eb = qb.pop_front();
      check($sformatf("b_seg%0d", eb.seg), out_b, eb.val);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    duty_a  = 8'd10;
    duty_b  = 8'd3;
    seg     = 0;

    repeat (3) @(negedge clk);
    check("reset_a", out_a, 1'b0);
    check("reset_b", out_b, 1'b0);

    // ---- dut_a: period p covers cycles r_a+1+100p .. r_a+100+100p ----
    r_a = cyc;
    rst_a_n = 1'b1;
    ep_a = r_a + 1;
    seg = 1;  period_a(10, 90); period_a(10, 90);  // duty 10, first period included
    seg = 2;  period_a(100, 0);                    // duty 100, no low pulse at wrap
    seg = 3;  period_a(100, 0);                    // duty 255 saturates
    seg = 4;  period_a(50, 50);                    // duty 50
    seg = 5;  period_a(0, 100);                    // duty 0
    seg = 6;  period_a(10, 90);                    // duty 10, change to 50 at cnt=30
    seg = 7;  period_a(50, 50);                    // change takes effect here
    seg = 8;  period_a(50, 50);                    // change just after wrap is ignored
    seg = 9;  period_a(20, 80);                    // ... until the next wrap
    seg = 10; push_a(1'b1, 40);                    // duty 50, reset at cnt=40

    wait_cyc(r_a + 199); duty_a = 8'd100;  // last clock before wrap edge
    wait_cyc(r_a + 250); duty_a = 8'd255;
    wait_cyc(r_a + 350); duty_a = 8'd50;
    wait_cyc(r_a + 450); duty_a = 8'd0;
    wait_cyc(r_a + 550); duty_a = 8'd10;
    wait_cyc(r_a + 630); duty_a = 8'd50;   // cnt=30 in period 6
    wait_cyc(r_a + 800); duty_a = 8'd20;   // first clock after wrap edge
    wait_cyc(r_a + 950); duty_a = 8'd50;

    wait_cyc(r_a + 1040);
    #2 rst_a_n = 1'b0;
    #1 check("async_reset_a", out_a, 1'b0);
    duty_a = 8'd20;
    repeat (2) @(negedge clk);
    check("reset_hold_a", out_a, 1'b0);

    r_a = cyc;
    rst_a_n = 1'b1;
    ep_a = r_a + 1;
    seg = 11; period_a(20, 80); period_a(20, 80);
    wait_cyc(r_a + 201);
    check("drain_a", (qa.size() == 0), 1'b1);

    // ---- dut_b: 40-clock periods, counter advances every 4th clock ----
    r_b = cyc;
    rst_b_n = 1'b1;
    ep_b = r_b + 1;
    seg = 20; period_b(12, 28); period_b(12, 28);  // duty 3 -> 12 high / 28 low
    seg = 21; period_b(40, 0);                     // duty 10 == PERIOD
    seg = 22; period_b(0, 40);                     // duty 0

    wait_cyc(r_b + 60);  duty_b = 8'd10;
    wait_cyc(r_b + 100); duty_b = 8'd0;
    wait_cyc(r_b + 161);
    check("drain_b", (qb.size() == 0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
